// File: rtl/ls_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ls_exec_unit
//  Description : Load/store execution unit. Takes one request at a time from
//                the load/store buffer and issues it to the memory controller.
//                Load results are extended and broadcast on the LS CDB.
//                Loads squashed by a misprediction flush finish their memory
//                access but are not broadcast. Stores always complete.
//                Opcode encoding {store, funct3}: LB=0 LH=1 LW=2 LBU=4 LHU=5
//                SB=8 SH=9 SW=A. Other codes are treated as word loads.
//                Optional build macro LS_EXEC_UNIT_PERF_CNT_EN adds the
//                load_cnt / store_cnt / stall_cnt performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module ls_exec_unit #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int OPENUM_W = 4,
    parameter int ROB_ID_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                ena_from_lsb,
    input  logic [OPENUM_W-1:0] openum_from_lsb,
    input  logic [ADDR_W-1:0]   mem_addr_from_lsb,
    input  logic [DATA_W-1:0]   store_value_from_lsb,
    input  logic [ROB_ID_W-1:0] rob_id_from_lsb,
    output logic                busy_to_lsb,
    output logic                ena_to_mc,
    output logic                rw_to_mc,
    output logic [ADDR_W-1:0]   addr_to_mc,
    output logic [1:0]          size_to_mc,
    output logic [DATA_W-1:0]   data_to_mc,
    input  logic                done_from_mc,
    input  logic [DATA_W-1:0]   data_from_mc,
    output logic                valid_to_cdb,
    output logic [ROB_ID_W-1:0] rob_id_to_cdb,
    output logic [DATA_W-1:0]   result_to_cdb,
    input  logic                commit_jump_flag_from_rob
`ifdef LS_EXEC_UNIT_PERF_CNT_EN
    ,
    output logic [31:0]         load_cnt,
    output logic [31:0]         store_cnt,
    output logic [31:0]         stall_cnt
`endif
);

    localparam logic [OPENUM_W-1:0] c_OP_LB  = OPENUM_W'(4'h0);
    localparam logic [OPENUM_W-1:0] c_OP_LH  = OPENUM_W'(4'h1);
    localparam logic [OPENUM_W-1:0] c_OP_LW  = OPENUM_W'(4'h2);
    localparam logic [OPENUM_W-1:0] c_OP_LBU = OPENUM_W'(4'h4);
    localparam logic [OPENUM_W-1:0] c_OP_LHU = OPENUM_W'(4'h5);
    localparam logic [OPENUM_W-1:0] c_OP_SB  = OPENUM_W'(4'h8);
    localparam logic [OPENUM_W-1:0] c_OP_SH  = OPENUM_W'(4'h9);
    localparam logic [OPENUM_W-1:0] c_OP_SW  = OPENUM_W'(4'hA);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_WAIT_MC = 1'b1
    } state_t;

    state_t                r_state;
    logic                  r_drop;
    logic [OPENUM_W-1:0]   r_op;
    logic [ROB_ID_W-1:0]   r_rob_id;

    logic                  w_req_is_store;
    logic [1:0]            w_req_size;
    logic                  w_accept;
    logic [DATA_W-1:0]     w_load_result;

    // A new request can only be taken from IDLE; the LSB sees busy as soon
    // as it raises ena, so it cannot issue twice before the state updates.
    assign busy_to_lsb = ena_from_lsb | (r_state != ST_IDLE);

    // A load arriving together with a flush is on the wrong path: drop it.
    assign w_accept = ena_from_lsb && (r_state == ST_IDLE)
                      && !(commit_jump_flag_from_rob && !w_req_is_store);

    // Decode the incoming opcode into direction and access size.
    always_comb begin
        w_req_is_store = 1'b0;
        w_req_size     = 2'b10;
        case (openum_from_lsb)
            c_OP_LB, c_OP_LBU: w_req_size = 2'b00;
            c_OP_LH, c_OP_LHU: w_req_size = 2'b01;
            c_OP_LW:           w_req_size = 2'b10;
            c_OP_SB: begin
                w_req_is_store = 1'b1;
                w_req_size     = 2'b00;
            end
            c_OP_SH: begin
                w_req_is_store = 1'b1;
                w_req_size     = 2'b01;
            end
            c_OP_SW: begin
                w_req_is_store = 1'b1;
                w_req_size     = 2'b10;
            end
            default: ;
        endcase
    end

    // Sign- or zero-extend the returned data according to the latched load opcode.
    always_comb begin
        w_load_result = data_from_mc;
        case (r_op)
            c_OP_LB:  w_load_result = {{(DATA_W-8){data_from_mc[7]}},   data_from_mc[7:0]};
            c_OP_LH:  w_load_result = {{(DATA_W-16){data_from_mc[15]}}, data_from_mc[15:0]};
            c_OP_LBU: w_load_result = {{(DATA_W-8){1'b0}},              data_from_mc[7:0]};
            c_OP_LHU: w_load_result = {{(DATA_W-16){1'b0}},             data_from_mc[15:0]};
            default:  ;
        endcase
    end

    // Request FSM: latch the request, hold it on the mc port until done,
    // then broadcast load results unless a flush squashed the load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_drop        <= 1'b0;
            r_op          <= '0;
            r_rob_id      <= '0;
            ena_to_mc     <= 1'b0;
            rw_to_mc      <= 1'b0;
            addr_to_mc    <= '0;
            size_to_mc    <= 2'b00;
            data_to_mc    <= '0;
            valid_to_cdb  <= 1'b0;
            rob_id_to_cdb <= '0;
            result_to_cdb <= '0;
        end else if (rdy) begin
            valid_to_cdb <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state    <= ST_WAIT_MC;
                        r_drop     <= 1'b0;
                        r_op       <= openum_from_lsb;
                        r_rob_id   <= rob_id_from_lsb;
                        ena_to_mc  <= 1'b1;
                        rw_to_mc   <= w_req_is_store;
                        addr_to_mc <= mem_addr_from_lsb;
                        size_to_mc <= w_req_size;
                        data_to_mc <= store_value_from_lsb;
                    end
                end
                ST_WAIT_MC: begin
                    if (commit_jump_flag_from_rob && !rw_to_mc) begin
                        r_drop <= 1'b1;
                    end
                    if (done_from_mc) begin
                        r_state   <= ST_IDLE;
                        r_drop    <= 1'b0;
                        ena_to_mc <= 1'b0;
                        // A flush in the done cycle itself squashes the load too.
                        if (!rw_to_mc && !r_drop && !commit_jump_flag_from_rob) begin
                            valid_to_cdb  <= 1'b1;
                            rob_id_to_cdb <= r_rob_id;
                            result_to_cdb <= w_load_result;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef LS_EXEC_UNIT_PERF_CNT_EN
    // Performance counters: completed loads/stores and cycles spent waiting on mc.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt  <= '0;
            store_cnt <= '0;
            stall_cnt <= '0;
        end else if (rdy && (r_state == ST_WAIT_MC)) begin
            stall_cnt <= stall_cnt + 32'd1;
            if (done_from_mc) begin
                if (rw_to_mc) begin
                    store_cnt <= store_cnt + 32'd1;
                end else begin
                    load_cnt  <= load_cnt + 32'd1;
                end
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ls_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ls_exec_unit
//  Description : Self-checking bench for ls_exec_unit. A memory-controller
//                model answers requests; expected mc requests and CDB results
//                are queued at issue time and checked by separate monitors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ls_exec_unit;

    localparam logic [3:0] c_LB  = 4'h0;
    localparam logic [3:0] c_LH  = 4'h1;
    localparam logic [3:0] c_LW  = 4'h2;
    localparam logic [3:0] c_LBU = 4'h4;
    localparam logic [3:0] c_LHU = 4'h5;
    localparam logic [3:0] c_SB  = 4'h8;
    localparam logic [3:0] c_SH  = 4'h9;
    localparam logic [3:0] c_SW  = 4'hA;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        ena_from_lsb;
    logic [3:0]  openum_from_lsb;
    logic [31:0] mem_addr_from_lsb;
    logic [31:0] store_value_from_lsb;
    logic [3:0]  rob_id_from_lsb;
    logic        busy_to_lsb;
    logic        ena_to_mc;
    logic        rw_to_mc;
    logic [31:0] addr_to_mc;
    logic [1:0]  size_to_mc;
    logic [31:0] data_to_mc;
    logic        done_from_mc;
    logic [31:0] data_from_mc;
    logic        valid_to_cdb;
    logic [3:0]  rob_id_to_cdb;
    logic [31:0] result_to_cdb;
    logic        commit_jump_flag_from_rob;

    always #5 clk = ~clk;

    ls_exec_unit #(
        .ADDR_W(32), .DATA_W(32), .OPENUM_W(4), .ROB_ID_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .ena_from_lsb(ena_from_lsb),
        .openum_from_lsb(openum_from_lsb),
        .mem_addr_from_lsb(mem_addr_from_lsb),
        .store_value_from_lsb(store_value_from_lsb),
        .rob_id_from_lsb(rob_id_from_lsb),
        .busy_to_lsb(busy_to_lsb),
        .ena_to_mc(ena_to_mc),
        .rw_to_mc(rw_to_mc),
        .addr_to_mc(addr_to_mc),
        .size_to_mc(size_to_mc),
        .data_to_mc(data_to_mc),
        .done_from_mc(done_from_mc),
        .data_from_mc(data_from_mc),
        .valid_to_cdb(valid_to_cdb),
        .rob_id_to_cdb(rob_id_to_cdb),
        .result_to_cdb(result_to_cdb),
        .commit_jump_flag_from_rob(commit_jump_flag_from_rob)
    );

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] data;
        logic [31:0] md;
        int          lat;
    } mc_t;

    typedef struct {
        logic [3:0]  rob;
        logic [31:0] res;
    } cdb_t;

    mc_t  mc_q[$];
    cdb_t cdb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pops = 0;
    bit   rand_rdy = 1'b0;
    bit   last_rdy = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_store(input logic [3:0] op);
        return (op == c_SB) || (op == c_SH) || (op == c_SW);
    endfunction

    function automatic logic [1:0] size_of(input logic [3:0] op);
        if (op == c_LB || op == c_LBU || op == c_SB) return 2'd0;
        if (op == c_LH || op == c_LHU || op == c_SH) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [31:0] load_value(input logic [3:0] op, input logic [31:0] d);
        logic [31:0] b;
        logic [31:0] h;
        b = d % 256;
        h = d % 65536;
        case (op)
            c_LB:    return (b >= 128)   ? b - 256   : b;
            c_LH:    return (h >= 32768) ? h - 65536 : h;
            c_LBU:   return b;
            c_LHU:   return h;
            default: return d;
        endcase
    endfunction

    // ---------------- memory controller model + mc-side monitor ----------------
    initial begin : mc_model
        mc_t  cur;
        int   wait_cnt;
        bit   active;
        logic srdy, srst, sdone;
        active = 1'b0;
        wait_cnt = 0;
        done_from_mc = 1'b0;
        data_from_mc = '0;
        cur = '{1'b0, 32'h0, 2'b0, 32'h0, 32'h0, 0};
        forever begin
            @(posedge clk);
            srdy = rdy;
            srst = rst;
            sdone = done_from_mc;
            last_rdy = rdy && !rst;
            #1;
            if (srst) begin
                active = 1'b0;
                done_from_mc = 1'b0;
            end else if (sdone && srdy) begin
                check("mc_ena_drops_on_done", ena_to_mc, 1'b0);
                active = 1'b0;
                done_from_mc = 1'b0;
            end else if (active) begin
                check("mc_request_held",
                      {ena_to_mc, rw_to_mc, addr_to_mc, size_to_mc, data_to_mc},
                      {1'b1, cur.rw, cur.addr, cur.size, cur.data});
                if (!done_from_mc) begin
                    if (wait_cnt == 0) begin
                        done_from_mc = 1'b1;
                        data_from_mc = cur.md;
                    end else begin
                        wait_cnt--;
                    end
                end
            end else if (ena_to_mc) begin
                if (mc_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mc_unexpected_request: got addr %0h expected no request", addr_to_mc);
                    cur = '{rw_to_mc, addr_to_mc, size_to_mc, data_to_mc, 32'h0, 0};
                end else begin
                    cur = mc_q.pop_front();
                    pops++;
                    check("mc_request",
                          {rw_to_mc, addr_to_mc, size_to_mc, data_to_mc},
                          {cur.rw, cur.addr, cur.size, cur.data});
                end
                active = 1'b1;
                wait_cnt = cur.lat;
            end
        end
    end

    // ---------------- CDB monitor ----------------
    initial begin : cdb_mon
        cdb_t e;
        forever begin
            @(negedge clk);
            if (valid_to_cdb && last_rdy) begin
                if (cdb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cdb_unexpected: got rob %0h result %0h expected no broadcast",
                             rob_id_to_cdb, result_to_cdb);
                end else begin
                    e = cdb_q.pop_front();
                    check("cdb_rob_id", rob_id_to_cdb, e.rob);
                    check("cdb_result", result_to_cdb, e.res);
                end
                if (!ena_from_lsb) check("busy_low_with_cdb", busy_to_lsb, 1'b0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(output bit took);
        @(posedge clk);
        took = rdy && !rst;
        #1;
        if (rand_rdy) rdy = ($urandom_range(0, 99) < 80);
    endtask

    task automatic wait_idle();
        bit t;
        int n;
        n = 0;
        while (busy_to_lsb && n < 300) begin
            tick(t);
            n++;
        end
        if (busy_to_lsb) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy %0b expected 0", busy_to_lsb);
        end
        tick(t);
        tick(t);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] val,
                         input logic [3:0] rob, input logic [31:0] md, input int lat,
                         input bit fl_same, input bit fl_mid);
        bit   took;
        int   n;
        bit   discard;
        n = 0;
        while (busy_to_lsb && n < 300) begin
            tick(took);
            n++;
        end
        if (busy_to_lsb) begin
            checks++;
            errors++;
            $display("FAIL issue_busy_timeout: got busy %0b expected 0", busy_to_lsb);
            return;
        end
        discard = fl_same && !is_store(op);
        if (!discard) mc_q.push_back('{is_store(op), addr, size_of(op), val, md, lat});
        if (!discard && !is_store(op) && !fl_mid) cdb_q.push_back('{rob, load_value(op, md)});
        openum_from_lsb = op;
        mem_addr_from_lsb = addr;
        store_value_from_lsb = val;
        rob_id_from_lsb = rob;
        commit_jump_flag_from_rob = fl_same;
        ena_from_lsb = 1'b1;
        n = 0;
        do begin
            tick(took);
            n++;
        end while (!took && n < 300);
        ena_from_lsb = 1'b0;
        commit_jump_flag_from_rob = fl_mid;
        check("mc_ena_after_accept", ena_to_mc, !discard);
        if (fl_mid) begin
            n = 0;
            do begin
                tick(took);
                n++;
            end while (!took && n < 300);
            commit_jump_flag_from_rob = 1'b0;
        end
    endtask

    initial begin : main
        bit          t;
        int          p0;
        int          n;
        logic [3:0]  ops[8];
        logic [3:0]  op;
        ops = '{c_LB, c_LH, c_LW, c_LBU, c_LHU, c_SB, c_SH, c_SW};
        rst = 1'b1;
        rdy = 1'b1;
        ena_from_lsb = 1'b0;
        openum_from_lsb = '0;
        mem_addr_from_lsb = '0;
        store_value_from_lsb = '0;
        rob_id_from_lsb = '0;
        commit_jump_flag_from_rob = 1'b0;
        repeat (3) tick(t);

        // reset state
        check("rst_ena_to_mc", ena_to_mc, 1'b0);
        check("rst_rw_to_mc", rw_to_mc, 1'b0);
        check("rst_addr_to_mc", addr_to_mc, 32'h0);
        check("rst_size_to_mc", size_to_mc, 2'b00);
        check("rst_data_to_mc", data_to_mc, 32'h0);
        check("rst_valid_to_cdb", valid_to_cdb, 1'b0);
        check("rst_rob_id_to_cdb", rob_id_to_cdb, 4'h0);
        check("rst_result_to_cdb", result_to_cdb, 32'h0);
        check("rst_busy", busy_to_lsb, 1'b0);
        rst = 1'b0;
        tick(t);

        // directed loads and stores
        issue(c_LB,  32'h0000_1000, 32'h0, 4'h3, 32'h0000_00F0, 2, 1'b0, 1'b0);
        wait_idle();
        issue(c_LHU, 32'h0000_1002, 32'h0, 4'h4, 32'h1234_ABCD, 1, 1'b0, 1'b0);
        issue(c_LH,  32'h0000_1002, 32'h0, 4'h5, 32'h1234_ABCD, 0, 1'b0, 1'b0);
        issue(c_SW,  32'h0000_2004, 32'hDEAD_BEEF, 4'h6, 32'h0, 3, 1'b0, 1'b0);
        wait_idle();

        // flush while a load waits on mc, then a normal load
        issue(c_LW,  32'h0000_3000, 32'h0, 4'h7, 32'h0000_55AA, 3, 1'b0, 1'b1);
        issue(c_LW,  32'h0000_3004, 32'h0, 4'h8, 32'h1234_5678, 1, 1'b0, 1'b0);
        wait_idle();

        // load presented with flush is discarded; store with flush still runs
        issue(c_LB,  32'h0000_4000, 32'h0, 4'h9, 32'h0000_0080, 1, 1'b1, 1'b0);
        issue(c_SB,  32'h0000_4001, 32'h0000_00A5, 4'hA, 32'h0, 1, 1'b1, 1'b0);
        wait_idle();

        // ena held across the done cycle: second request only after IDLE
        mc_q.push_back('{1'b0, 32'h0000_5000, 2'd2, 32'h0, 32'hCAFE_F00D, 2});
        mc_q.push_back('{1'b0, 32'h0000_5008, 2'd0, 32'h0, 32'h0000_007F, 1});
        cdb_q.push_back('{4'hB, 32'hCAFE_F00D});
        cdb_q.push_back('{4'hC, 32'h0000_007F});
        p0 = pops;
        openum_from_lsb = c_LW;
        mem_addr_from_lsb = 32'h0000_5000;
        store_value_from_lsb = 32'h0;
        rob_id_from_lsb = 4'hB;
        ena_from_lsb = 1'b1;
        tick(t);
        openum_from_lsb = c_LBU;
        mem_addr_from_lsb = 32'h0000_5008;
        rob_id_from_lsb = 4'hC;
        n = 0;
        while (pops < p0 + 2 && n < 50) begin
            tick(t);
            check("busy_held_while_ena", busy_to_lsb, 1'b1);
            n++;
        end
        check("second_request_issued", pops - p0, 2);
        ena_from_lsb = 1'b0;
        wait_idle();

        // reset in WAIT_MC, then rdy low: everything at reset values and frozen
        issue(c_LW, 32'h0000_6000, 32'h0, 4'hD, 32'h1111_1111, 20, 1'b0, 1'b1);
        tick(t);
        rst = 1'b1;
        tick(t);
        rst = 1'b0;
        rdy = 1'b0;
        openum_from_lsb = c_SW;
        mem_addr_from_lsb = 32'h0000_7000;
        store_value_from_lsb = 32'h7777_7777;
        ena_from_lsb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(t);
            check("frozen_mc_outputs",
                  {ena_to_mc, rw_to_mc, addr_to_mc, size_to_mc, data_to_mc}, '0);
            check("frozen_cdb_outputs", {valid_to_cdb, rob_id_to_cdb, result_to_cdb}, '0);
        end
        ena_from_lsb = 1'b0;
        rdy = 1'b1;
        tick(t);
        check("post_reset_ena_to_mc", ena_to_mc, 1'b0);
        wait_idle();

        // randomized traffic with random rdy stalls and flushes
        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            op = ops[$urandom_range(0, 7)];
            issue(op, $urandom, $urandom, 4'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 4), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
        end
        rand_rdy = 1'b0;
        rdy = 1'b1;
        wait_idle();
        repeat (3) tick(t);
        check("cdb_queue_drained", cdb_q.size(), 0);
        check("mc_queue_drained", mc_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ls_exec_unit.md
LS_EXEC_UNIT -- requirements
Module: ls_exec_unit

Interface
REQ-001 SHALL have parameter: ADDR_W, 32, memory address width.
REQ-002 SHALL have parameter: DATA_W, 32, data/result width.
REQ-003 SHALL have port: clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-004 SHALL have port: rst  in  1  synchronous active-high reset.
REQ-005 SHALL have port: rdy  in  1  global ready; when low, all state is frozen.
REQ-006 SHALL have ports: ena_from_lsb  in  1; openum_from_lsb  in  OPENUM width; mem_addr_from_lsb  in  ADDR_W; store_value_from_lsb  in  DATA_W; rob_id_from_lsb  in  ROB_ID width. These form the request from the load/store buffer.
REQ-007 SHALL have port: busy_to_lsb  out  1  unit cannot accept a request this cycle.
REQ-008 SHALL have ports to the memory controller: ena_to_mc  out  1; rw_to_mc  out  1 (0=read, 1=write); addr_to_mc  out  ADDR_W; size_to_mc  out  2 (00 byte, 01 half, 10 word); data_to_mc  out  DATA_W.
REQ-009 SHALL have ports from the memory controller: done_from_mc  in  1; data_from_mc  in  DATA_W.
REQ-010 SHALL have ports to the LS CDB: valid_to_cdb  out  1; rob_id_to_cdb  out  ROB_ID width; result_to_cdb  out  DATA_W.
REQ-011 SHALL have port: commit_jump_flag_from_rob  in  1  misprediction flush.

Function
REQ-012 SHALL implement FSM states IDLE and WAIT_MC.
- Request accepted while in IDLE with ena_from_lsb=1 -> WAIT_MC.
- done_from_mc in WAIT_MC -> IDLE.
REQ-013 busy_to_lsb SHALL be combinational: ena_from_lsb OR (state != IDLE). This prevents back-to-back issue before the state register updates.
REQ-014 On acceptance, SHALL register the memory request and drive ena_to_mc=1 from the next cycle until done_from_mc.
- rw, addr, size and data (store_value) SHALL be held stable throughout.
- Size map: LB/LBU/SB=00, LH/LHU/SH=01, LW/SW=10.
REQ-015 Load completion: in the cycle after done_from_mc, SHALL assert valid_to_cdb for exactly one cycle, with the latched rob_id and the extended result.
- LB: sign-extend data_from_mc[7:0].
- LH: sign-extend data_from_mc[15:0].
- LBU/LHU: zero-extend.
- LW: pass data_from_mc through.
REQ-016 Store completion SHALL produce no CDB broadcast; the unit returns to IDLE only.
REQ-017 ena_to_mc SHALL drop in the same edge that registers done_from_mc; a new request SHALL NOT be issued to mc in that cycle.
REQ-018 Minimum latency: accept at edge T, ena_to_mc high from T+1; with done at cycle D, CDB valid at D+1 and busy low at D+1 (absent new ena).
REQ-019 Flush during a load in WAIT_MC SHALL set a drop flag.
- The mc transaction runs to completion.
- No CDB broadcast results; the drop flag clears on return to IDLE.
REQ-020 A load presented together with commit_jump_flag_from_rob in the same cycle SHALL be discarded and never issued to mc.
REQ-021 Stores SHALL complete regardless of flush, since they are already committed.
REQ-022 ena_from_lsb arriving while not IDLE SHALL be ignored. The LSB guarantees this does not happen; the bench checks that it is ignored.
REQ-023 When rdy=0, SHALL hold all state and outputs. done_from_mc is not sampled.

Reset
REQ-024 On rst, SHALL set:
- state=IDLE and drop flag=0.
- ena_to_mc=0, rw_to_mc=0, addr_to_mc=0, size_to_mc=00, data_to_mc=0.
- valid_to_cdb=0, rob_id_to_cdb=0, result_to_cdb=0.
REQ-025 Reset mid-transaction SHALL abandon the access: ena_to_mc=0 on the next cycle, and no CDB output.

Configuration
REQ-026 Macro LS_EXEC_UNIT_PERF_CNT_EN:
- Defined: adds 32-bit outputs load_cnt, store_cnt and stall_cnt.
  - load_cnt and store_cnt count completed loads and stores.
  - stall_cnt counts cycles in WAIT_MC.
  - All counters reset to 0 and wrap on overflow.
- Undefined: the ports and counters are absent, with identical functional behaviour otherwise.

Verification
REQ-027 LB, addr 0x1000, mc returns 0x000000F0 after 3 cycles -> one-cycle CDB valid, result 0xFFFFFFF0, rob_id echoed.
REQ-028 LHU, mc data 0x1234ABCD -> result 0x0000ABCD; LH with same data -> 0xFFFFABCD.
REQ-029 SW, addr 0x2004, value 0xDEADBEEF -> ena_to_mc=1, rw=1, size=10, data held until done; no valid_to_cdb.
REQ-030 Load in WAIT_MC, flush pulsed -> mc completes, valid_to_cdb stays 0, busy low the cycle after done; the next load broadcasts normally.
REQ-031 ena_from_lsb held high across the done cycle -> busy_to_lsb stays 1, the second request is accepted only after IDLE, and no overlap on ena_to_mc.
REQ-032 rst asserted in WAIT_MC, then rdy=0 for 5 cycles -> all outputs at reset values, and nothing changes while rdy is low.
